// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard control signal bundle
interface hazard_ctrl_if;
  logic       ID_Ex_MemRead;
  logic [4:0] ID_Ex_Rt;
  logic [4:0] If_Id_Rs;
  logic [4:0] If_Id_Rt;
  logic       If_Id_UsesRt;
  logic       Md_Start;
  logic       Branch_Taken;
  logic       PC_Wr;
  logic       If_Id_Wr;
  logic       ID_Ex_Wr;
  logic       If_Id_Flush;
  logic       ID_Ex_Flush;
  logic       Ex_Mem_Flush;

  modport master (
    output ID_Ex_MemRead, ID_Ex_Rt, If_Id_Rs, If_Id_Rt, If_Id_UsesRt, Md_Start, Branch_Taken,
    input  PC_Wr, If_Id_Wr, ID_Ex_Wr, If_Id_Flush, ID_Ex_Flush, Ex_Mem_Flush
  );

  modport slave (
    input  ID_Ex_MemRead, ID_Ex_Rt, If_Id_Rs, If_Id_Rt, If_Id_UsesRt, Md_Start, Branch_Taken,
    output PC_Wr, If_Id_Wr, ID_Ex_Wr, If_Id_Flush, ID_Ex_Flush, Ex_Mem_Flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / multi-cycle / branch hazard control unit
// Optional stall counter port Stall_Cnt enabled by macro HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]   Stall_Cnt
`endif
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam bit MD_STALLS = (MD_LAT >= 2);
  localparam bit MD_MULTI  = (MD_LAT >= 3);
  localparam int MD_LOAD_I = MD_MULTI ? (MD_LAT - 3) : 0;
  localparam logic [3:0] MD_LOAD = 4'(MD_LOAD_I);

  state_t     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       lu_hit;
  logic       md_start_run;
  logic       md_stall;
  logic       pc_wr, if_id_wr, id_ex_wr;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;

  assign lu_hit = hz.ID_Ex_MemRead & (hz.ID_Ex_Rt != 5'd0) &
                  ((hz.ID_Ex_Rt == hz.If_Id_Rs) |
                   (hz.If_Id_UsesRt & (hz.ID_Ex_Rt == hz.If_Id_Rt)));

  // Md_Start only counts in RUN; a second start while busy is ignored.
  assign md_start_run = (state_q == RUN) & hz.Md_Start;
  assign md_stall     = (state_q == MD_BUSY) | (md_start_run & MD_STALLS);

  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_wr     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (hz.Branch_Taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (md_stall) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (lu_hit) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  assign hz.PC_Wr        = pc_wr;
  assign hz.If_Id_Wr     = if_id_wr;
  assign hz.ID_Ex_Wr     = id_ex_wr;
  assign hz.If_Id_Flush  = if_id_flush;
  assign hz.ID_Ex_Flush  = id_ex_flush;
  assign hz.Ex_Mem_Flush = ex_mem_flush;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (hz.Branch_Taken) begin
      state_d  = RUN;
      md_cnt_d = 4'd0;
    end else if (state_q == RUN) begin
      if (md_start_run && MD_MULTI) begin
        state_d  = MD_BUSY;
        md_cnt_d = MD_LOAD;
      end
    end else if (md_cnt_q == 4'd0) begin
      state_d = RUN;
    end else begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wr && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl at MD_LAT 4, 8 and 2
module tb_hazard_ctrl;

  // {PC_Wr, If_Id_Wr, ID_Ex_Wr, If_Id_Flush, ID_Ex_Flush, Ex_Mem_Flush}
  localparam logic [5:0] NRM = 6'b111_000;
  localparam logic [5:0] LU  = 6'b001_010;
  localparam logic [5:0] MD  = 6'b000_001;
  localparam logic [5:0] BR  = 6'b111_111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       memrd, uses_rt, md_start, br;
  logic [4:0] ex_rt, id_rs, id_rt;

  int n_tests = 0;
  int n_fail  = 0;

  string       q_nm[$];
  logic [5:0]  q_e4[$];
  logic [5:0]  q_e8[$];
  logic [5:0]  q_e2[$];
  logic [15:0] q_cnt[$];
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  hazard_ctrl_if if4 ();
  hazard_ctrl_if if8 ();
  hazard_ctrl_if if2 ();

  assign if4.ID_Ex_MemRead = memrd;
  assign if4.ID_Ex_Rt      = ex_rt;
  assign if4.If_Id_Rs      = id_rs;
  assign if4.If_Id_Rt      = id_rt;
  assign if4.If_Id_UsesRt  = uses_rt;
  assign if4.Md_Start      = md_start;
  assign if4.Branch_Taken  = br;
  assign if8.ID_Ex_MemRead = memrd;
  assign if8.ID_Ex_Rt      = ex_rt;
  assign if8.If_Id_Rs      = id_rs;
  assign if8.If_Id_Rt      = id_rt;
  assign if8.If_Id_UsesRt  = uses_rt;
  assign if8.Md_Start      = md_start;
  assign if8.Branch_Taken  = br;
  assign if2.ID_Ex_MemRead = memrd;
  assign if2.ID_Ex_Rt      = ex_rt;
  assign if2.If_Id_Rs      = id_rs;
  assign if2.If_Id_Rt      = id_rt;
  assign if2.If_Id_UsesRt  = uses_rt;
  assign if2.Md_Start      = md_start;
  assign if2.Branch_Taken  = br;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] cnt4, cnt8, cnt2;
  hazard_ctrl #(.MD_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .hz(if4), .Stall_Cnt(cnt4));
  hazard_ctrl #(.MD_LAT(8)) u8 (.clk(clk), .rst_n(rst_n), .hz(if8), .Stall_Cnt(cnt8));
  hazard_ctrl #(.MD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .hz(if2), .Stall_Cnt(cnt2));
`else
  hazard_ctrl #(.MD_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .hz(if4));
  hazard_ctrl #(.MD_LAT(8)) u8 (.clk(clk), .rst_n(rst_n), .hz(if8));
  hazard_ctrl #(.MD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .hz(if2));
`endif

  function automatic logic [5:0] outs(input logic a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  task automatic check6(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle that has one and compares.
  always @(negedge clk) begin
    if (q_nm.size() != 0) begin
      string       nm;
      logic [5:0]  e4, e8, e2;
      logic [15:0] ec;
      nm = q_nm.pop_front();
      e4 = q_e4.pop_front();
      e8 = q_e8.pop_front();
      e2 = q_e2.pop_front();
      ec = q_cnt.pop_front();
      check6({nm, "/lat4"}, outs(if4.PC_Wr, if4.If_Id_Wr, if4.ID_Ex_Wr,
                                  if4.If_Id_Flush, if4.ID_Ex_Flush, if4.Ex_Mem_Flush), e4);
      check6({nm, "/lat8"}, outs(if8.PC_Wr, if8.If_Id_Wr, if8.ID_Ex_Wr,
                                  if8.If_Id_Flush, if8.ID_Ex_Flush, if8.Ex_Mem_Flush), e8);
      check6({nm, "/lat2"}, outs(if2.PC_Wr, if2.If_Id_Wr, if2.ID_Ex_Wr,
                                  if2.If_Id_Flush, if2.ID_Ex_Flush, if2.Ex_Mem_Flush), e2);
`ifdef HAZARD_PERF_CNT_EN
      n_tests++;
      if (cnt4 !== ec) begin
        n_fail++;
        $display("FAIL %s/stall_cnt: got %0d expected %0d", nm, cnt4, ec);
      end
`else
      if (ec === 16'hx) $display("unexpected x in count model");
`endif
    end
  end

  // One clock cycle with the current inputs; chk=0 skips comparison but still updates the counter model.
  task automatic step(input string nm, input bit chk, input logic [5:0] e4,
                      input logic [5:0] e8, input logic [5:0] e2);
    if (chk) begin
      q_nm.push_back(nm);
      q_e4.push_back(e4);
      q_e8.push_back(e8);
      q_e2.push_back(e2);
      q_cnt.push_back(exp_cnt);
    end
    @(posedge clk);
    if (!rst_n) exp_cnt = 16'd0;
    else if (!e4[5] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  task automatic clr();
    memrd = 0; uses_rt = 0; md_start = 0; br = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  initial begin
    clr();
    rst_n = 0;
    step("rst", 0, NRM, NRM, NRM);
    step("rst", 0, NRM, NRM, NRM);
    rst_n = 1;
    step("idle", 1, NRM, NRM, NRM);

    memrd = 1; ex_rt = 5; id_rs = 5;
    step("lu_rs", 1, LU, LU, LU);
    clr();
    step("lu_after", 1, NRM, NRM, NRM);

    memrd = 1; ex_rt = 0; id_rs = 0;
    step("lu_r0", 1, NRM, NRM, NRM);
    ex_rt = 7; id_rs = 3; id_rt = 7; uses_rt = 0;
    step("lu_rt_unused", 1, NRM, NRM, NRM);
    uses_rt = 1;
    step("lu_rt_used", 1, LU, LU, LU);
    clr();

    md_start = 1;
    step("md_t0", 1, MD, MD, MD);
    md_start = 0;
    step("md_t1", 1, MD, MD, NRM);
    md_start = 1;
    step("md_t2_ign", 1, MD, MD, MD);
    md_start = 0;
    step("md_t3", 1, NRM, MD, NRM);
    step("md_t4", 1, NRM, MD, NRM);
    step("md_t5", 1, NRM, MD, NRM);
    step("md_t6", 1, NRM, MD, NRM);
    step("md_t7", 1, NRM, NRM, NRM);

    md_start = 1;
    step("br_t0", 1, MD, MD, MD);
    md_start = 0; br = 1;
    step("br_t1", 1, BR, BR, BR);
    br = 0;
    step("br_t2", 1, NRM, NRM, NRM);

    md_start = 1; memrd = 1; ex_rt = 9; id_rs = 9;
    step("mdlu_t0", 1, MD, MD, MD);
    md_start = 0;
    step("mdlu_t1", 1, MD, MD, LU);
    step("mdlu_t2", 1, MD, MD, LU);
    step("mdlu_t3", 1, LU, MD, LU);
    br = 1;
    step("mdlu_br", 1, BR, BR, BR);
    clr();
    step("mdlu_t5", 1, NRM, NRM, NRM);

    md_start = 1;
    step("rst_t0", 1, MD, MD, MD);
    md_start = 0; rst_n = 0;
    step("rst_t1", 1, MD, MD, NRM);
    rst_n = 1;
    step("rst_t2", 1, NRM, NRM, NRM);
    step("rst_t3", 1, NRM, NRM, NRM);

`ifdef HAZARD_PERF_CNT_EN
    rst_n = 0;
    step("cnt_rst", 0, NRM, NRM, NRM);
    rst_n = 1;
    md_start = 1;
    step("cnt_m0", 1, MD, MD, MD);
    md_start = 0;
    step("cnt_m1", 1, MD, MD, NRM);
    step("cnt_m2", 1, MD, MD, NRM);
    step("cnt_three", 1, NRM, MD, NRM);
    memrd = 1; ex_rt = 4; id_rs = 4;
    for (int i = 0; i < 65540; i++) step("sat", 0, LU, LU, LU);
    step("cnt_sat", 1, LU, LU, LU);
    step("cnt_hold", 1, LU, LU, LU);
    clr();
`endif

    for (int i = 0; i < 4 && q_nm.size() != 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (q_nm.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_nm.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
